// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared types, error codes and parameter checks for the memory-map controller
package mem_map_pkg;
  typedef enum logic [2:0] {R_ROM, R_RAM, R_IO, R_INT, R_FAULT} region_t;
  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  localparam logic [1:0] C_MISALIGN = 2'd0;
  localparam logic [1:0] C_ROM_WR   = 2'd1;
  localparam logic [1:0] C_UNMAPPED = 2'd2;
  localparam logic [1:0] C_CONFLICT = 2'd3;
  localparam int WAIT_W = 8;
  function automatic bit io_fits(input longint base, input longint n, input int aw);
    return (base + 2 * n) < (longint'(1) << aw);
  endfunction
endpackage

// File: rtl/mem_map_decode.sv
// mem_map_decode: combinational address/direction decode into region, channel, fault and wait count
module mem_map_decode
  import mem_map_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int ROM_TOP  = 16'h00FF,
  parameter int RAM_TOP  = 16'h03FF,
  parameter int IO_BASE  = 16'h0400,
  parameter int N_IO     = 4,
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 0,
  parameter int IDX_W    = (N_IO > 1) ? $clog2(N_IO) : 1
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              re,
  input  logic              we,
  output region_t           region,
  output logic [IDX_W-1:0]  io_idx,
  output logic              fault,
  output logic [1:0]        cause,
  output logic [WAIT_W-1:0] wait_cnt
);
  logic [ADDR_W-1:0] off;
  logic in_io, is_int;
  assign off    = address - ADDR_W'(IO_BASE);
  assign in_io  = (address >= ADDR_W'(IO_BASE)) && (off < ADDR_W'(2 * N_IO));
  assign is_int = address == ADDR_W'(IO_BASE + 2 * N_IO);
  assign io_idx = IDX_W'(off >> 1);
  always_comb begin
    region   = R_FAULT;
    fault    = 1'b1;
    cause    = C_UNMAPPED;
    wait_cnt = '0;
    if (address[0]) cause = C_MISALIGN;
    else if (re && we) cause = C_CONFLICT;
    else if (address <= ADDR_W'(ROM_TOP)) begin
      cause    = we ? C_ROM_WR : C_UNMAPPED;
      fault    = we;
      region   = we ? R_FAULT : R_ROM;
      wait_cnt = we ? '0 : WAIT_W'(ROM_WAIT);
    end else if (address <= ADDR_W'(RAM_TOP)) begin
      region   = R_RAM;
      fault    = 1'b0;
      wait_cnt = WAIT_W'(RAM_WAIT);
    end else if (in_io || is_int) begin
      region = in_io ? R_IO : R_INT;
      fault  = 1'b0;
    end
  end
endmodule

// File: rtl/mem_map_ctrl.sv
// mem_map_ctrl: sequenced memory-map controller with wait states, strobes, error record and interrupt latch
module mem_map_ctrl
  import mem_map_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int ROM_TOP  = 16'h00FF,
  parameter int RAM_TOP  = 16'h03FF,
  parameter int IO_BASE  = 16'h0400,
  parameter int N_IO     = 4,
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] address,
  output logic              ack,
  output logic              mem_err,
  output logic              err_sticky,
  output logic [1:0]        err_cause,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr,
  output logic              re_out,
  output logic              we_out,
  output logic [N_IO-1:0]   io_rd,
  output logic [N_IO-1:0]   io_wr,
  output logic              int_req,
  input  logic              int_ack
);
  localparam int IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;
  if (!io_fits(IO_BASE, N_IO, ADDR_W)) begin : g_io_range
    $error("mem_map_ctrl: interrupt register lies outside the address space");
  end
  region_t d_region, region_q;
  logic [IDX_W-1:0] d_idx, idx_q;
  logic d_fault, fault_q, dir_q, busy, live, start;
  logic [1:0] d_cause, cause_q;
  logic [WAIT_W-1:0] d_wait, cnt_q;
  logic [ADDR_W-1:0] addr_q;
  state_t state_q, state_d;
  mem_map_decode #(
    .ADDR_W(ADDR_W), .ROM_TOP(ROM_TOP), .RAM_TOP(RAM_TOP), .IO_BASE(IO_BASE),
    .N_IO(N_IO), .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT), .IDX_W(IDX_W)
  ) u_decode (
    .address(address), .re(re_in), .we(we_in), .region(d_region), .io_idx(d_idx),
    .fault(d_fault), .cause(d_cause), .wait_cnt(d_wait)
  );
  assign start = (state_q == S_IDLE) && (re_in || we_in);
  always_comb begin
    state_d = state_q;
    state_d = (state_q == S_IDLE) ? (start ? S_ACCESS : S_IDLE)
                                  : ((cnt_q == '0) ? S_IDLE : S_ACCESS);
  end
  assign busy    = state_q == S_ACCESS;
  assign live    = busy && !fault_q;
  assign ack     = busy && (cnt_q == '0);
  assign mem_err = ack && fault_q;
  assign re_out  = live && !dir_q && (region_q == R_ROM || region_q == R_RAM);
  assign we_out  = live && dir_q && (region_q == R_RAM);
  assign io_rd   = (live && !dir_q && region_q == R_IO) ? (N_IO'(1) << idx_q) : '0;
  assign io_wr   = (live && dir_q && region_q == R_IO) ? (N_IO'(1) << idx_q) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      region_q   <= R_FAULT;
      idx_q      <= '0;
      dir_q      <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      err_sticky <= 1'b0;
      err_cause  <= '0;
      err_addr   <= '0;
      int_req    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        region_q <= d_region;
        idx_q    <= d_idx;
        dir_q    <= we_in;
        fault_q  <= d_fault;
        cause_q  <= d_cause;
        cnt_q    <= d_wait;
        addr_q   <= address;
      end else if (busy && cnt_q != '0) cnt_q <= cnt_q - WAIT_W'(1);
      // a new fault beats a simultaneous clear; otherwise the first fault is kept
      if (mem_err && (!err_sticky || err_clr)) begin
        err_sticky <= 1'b1;
        err_cause  <= cause_q;
        err_addr   <= addr_q;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_cause  <= '0;
        err_addr   <= '0;
      end
      int_req <= (ack && !fault_q && region_q == R_INT) || (int_req && !int_ack);
    end
  end
endmodule
